// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler: HDMI data-island sequencer and packet-slot arbiter; define HDMI_SCHED_INFOFRAME_VBLANK_EN to limit InfoFrames to vertical blanking
module hdmi_island_scheduler #(
  parameter int VIDEO_X_BITWIDTH = 12,
  parameter int VIDEO_Y_BITWIDTH = 11,
  parameter int ISLAND_OFFSET = 4,
  parameter int MAX_PACKETS = 18
) (
  input  logic                        I_clk_pixel,
  input  logic                        I_reset_n,
  input  logic [VIDEO_X_BITWIDTH-1:0] pixX,
  input  logic [VIDEO_Y_BITWIDTH-1:0] pixY,
  input  logic [VIDEO_X_BITWIDTH-1:0] frameWidth,
  input  logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
  input  logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
  input  logic [3:0]                  I_req,
  output logic [3:0]                  O_grant,
  output logic                        O_preamble,
  output logic                        O_guard,
  output logic                        O_island,
  output logic                        O_pkt_start,
  output logic [4:0]                  O_pkt_idx
);
  localparam int XW = VIDEO_X_BITWIDTH + 1;
  localparam logic [4:0] MAX_P = 5'(MAX_PACKETS);
  typedef enum logic [2:0] {IDLE, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD} state_t;
  state_t state, nxt;
  logic [4:0] cnt, nxt_cnt, pkts, nxt_pkts, idx_d;
  logic [XW-1:0] start_q, fw_q, island_col, next_start;
  logic [3:0] elig, pick, nxt_grant;
  logic start_ok, budget_ok, pre_d, guard_d, island_d, pkt_start_d;
`ifdef HDMI_SCHED_INFOFRAME_VBLANK_EN
  assign elig = I_req & {{2{pixY >= screenHeight}}, 2'b11};
`else
  logic unused_vblank;
  assign unused_vblank = ^{pixY, screenHeight};
  assign elig = I_req;
`endif
  assign pick = elig[1] ? 4'b0010 : elig[0] ? 4'b0001 : elig[2] ? 4'b0100 : elig[3] ? 4'b1000 : 4'b0000;
  assign island_col = XW'(screenWidth) + XW'(ISLAND_OFFSET);
  assign start_ok = ({1'b0, pixX} == island_col) && (|elig) && (island_col + XW'(56) <= {1'b0, frameWidth});
  assign next_start = start_q + XW'(10) + XW'({pkts, 5'd0});
  assign budget_ok = next_start + XW'(46) <= fw_q;
  // state, column and packet counters plus island geometry latched at start
  always_ff @(posedge I_clk_pixel or negedge I_reset_n)
    if (!I_reset_n) begin
      state <= IDLE;
      cnt <= '0;
      pkts <= '0;
      start_q <= '0;
      fw_q <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      pkts <= nxt_pkts;
      if (state == IDLE && start_ok) begin
        start_q <= island_col;
        fw_q <= {1'b0, frameWidth};
      end
    end
  // next state: fixed-length periods, packet decisions on the last guard column and packet column 31
  always_comb begin
    nxt = state;
    nxt_cnt = cnt + 5'd1;
    nxt_pkts = pkts;
    nxt_grant = 4'b0000;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        nxt_pkts = '0;
        if (start_ok) nxt = PREAMBLE;
      end
      PREAMBLE: if (cnt == 5'd7) begin
        nxt = LEAD_GUARD;
        nxt_cnt = '0;
      end
      LEAD_GUARD: if (cnt == 5'd1) begin
        nxt_cnt = '0;
        nxt = budget_ok ? PACKET : TRAIL_GUARD;
        nxt_grant = budget_ok ? pick : 4'b0000;
        nxt_pkts = budget_ok ? pkts + 5'd1 : pkts;
      end
      PACKET: if (cnt == 5'd31) begin
        nxt_cnt = '0;
        if ((|elig) && budget_ok && pkts < MAX_P) begin
          nxt_grant = pick;
          nxt_pkts = pkts + 5'd1;
        end else nxt = TRAIL_GUARD;
      end
      TRAIL_GUARD: if (cnt == 5'd1) begin
        nxt = IDLE;
        nxt_cnt = '0;
      end
      default: nxt = IDLE;
    endcase
  end
  // output decode of the column about to be registered
  always_comb begin
    pre_d = nxt == PREAMBLE;
    guard_d = nxt == LEAD_GUARD || nxt == TRAIL_GUARD;
    island_d = guard_d || nxt == PACKET;
    pkt_start_d = nxt == PACKET && nxt_cnt == 5'd0;
    idx_d = nxt == PACKET ? nxt_cnt : 5'd0;
  end
  // registered outputs, one column behind pixX
  always_ff @(posedge I_clk_pixel or negedge I_reset_n)
    if (!I_reset_n) begin
      O_grant <= '0;
      O_preamble <= 1'b0;
      O_guard <= 1'b0;
      O_island <= 1'b0;
      O_pkt_start <= 1'b0;
      O_pkt_idx <= '0;
    end else begin
      O_grant <= nxt_grant;
      O_preamble <= pre_d;
      O_guard <= guard_d;
      O_island <= island_d;
      O_pkt_start <= pkt_start_d;
      O_pkt_idx <= idx_d;
    end
endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb_hdmi_island_scheduler: line-by-line raster stimulus with a column model and a grant scoreboard
module tb_hdmi_island_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, pre, guard, island, pkt_start;
  logic [11:0] pix_x, fw, sw;
  logic [10:0] pix_y, sh;
  logic [3:0] req, grant;
  logic [4:0] pkt_idx;
  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];
  hdmi_island_scheduler dut (
    .I_clk_pixel(clk),
    .I_reset_n(rst_n),
    .pixX(pix_x),
    .pixY(pix_y),
    .frameWidth(fw),
    .screenWidth(sw),
    .screenHeight(sh),
    .I_req(req),
    .O_grant(grant),
    .O_preamble(pre),
    .O_guard(guard),
    .O_island(island),
    .O_pkt_start(pkt_start),
    .O_pkt_idx(pkt_idx)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [8:0] model(input int x, input int s, input int npk);
    int p0, e, idx;
    logic pr, lg, pk, tg;
    if (npk == 0) return 9'd0;
    p0 = s + 10;
    e = p0 + 32 * npk;
    pr = x >= s && x <= s + 7;
    lg = x >= s + 8 && x <= s + 9;
    pk = x >= p0 && x < e;
    tg = x >= e && x <= e + 1;
    idx = pk ? (x - p0) % 32 : 0;
    return {pr, lg | tg, lg | pk | tg, pk && idx == 0, 5'(idx)};
  endfunction
  task automatic run_line(input int y, input int npk, input bit drop, input int clr_col, input int rst_col);
    int s;
    bit dead;
    logic [8:0] m;
    logic [3:0] eg;
    s = int'(sw) + 4;
    dead = 1'b0;
    for (int x = 0; x < int'(fw); x++) begin
      pix_x = 12'(x);
      pix_y = 11'(y);
      @(posedge clk);
      #1;
      m = dead ? 9'd0 : model(x, s, npk);
      check($sformatf("cols@%0d", x), 32'({pre, guard, island, pkt_start, pkt_idx}), 32'(m));
      if (m[5]) begin
        eg = 4'bxxxx;
        if (exp_q.size() > 0) eg = exp_q.pop_front();
        check($sformatf("grant@%0d", x), 32'(grant), 32'(eg));
      end else check($sformatf("no_grant@%0d", x), 32'(grant), 32'd0);
      if (drop) req = req & ~grant;
      if (x == clr_col) req = 4'b0000;
      if (x == rst_col) begin
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'({grant, pre, guard, island, pkt_start, pkt_idx}), 32'd0);
        #1;
        rst_n = 1'b1;
        dead = 1'b1;
        exp_q.delete();
      end
    end
    check("q_empty", 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    req = 4'b0000;
    pix_x = '0;
    pix_y = '0;
    fw = 12'd1650;
    sw = 12'd1280;
    sh = 11'd720;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 32'({grant, pre, guard, island, pkt_start, pkt_idx}), 32'd0);
    rst_n = 1'b1;
    req = 4'b1111;
    repeat (10) exp_q.push_back(4'b0010);
    run_line(740, 10, 1'b0, -1, -1);
    req = 4'b0011;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    run_line(740, 2, 1'b1, -1, -1);
    req = 4'b1101;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    run_line(740, 3, 1'b1, -1, -1);
    req = 4'b0000;
    run_line(740, 0, 1'b0, -1, -1);
    req = 4'b0100;
    exp_q.push_back(4'b0000);
    run_line(740, 1, 1'b0, 1286, -1);
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    run_line(740, 10, 1'b0, -1, 1284 + 10 + 17);
    repeat (10) exp_q.push_back(4'b0010);
    run_line(741, 10, 1'b0, -1, -1);
    req = 4'b0100;
`ifdef HDMI_SCHED_INFOFRAME_VBLANK_EN
    run_line(100, 0, 1'b0, -1, -1);
`else
    repeat (10) exp_q.push_back(4'b0100);
    run_line(100, 10, 1'b0, -1, -1);
`endif
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    run_line(725, 1, 1'b1, -1, -1);
    fw = 12'd1320;
    req = 4'b1111;
    run_line(740, 0, 1'b0, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
